// File: rtl/axis_mux_serializer_in.sv
// rtl/axis_mux_serializer_in.sv - round-robin AXIS packet arbiter and beat-to-flit serializer with credit flow control
module axis_mux_serializer_in #(
    parameter int NUM_CHANNELS         = 4,
    parameter int TDATA_WIDTH          = 32,
    parameter int TID_WIDTH            = 2,
    parameter int TDEST_WIDTH          = 2,
    parameter int SERIALIZATION_FACTOR = 2,
    parameter int FLIT_WIDTH           = TDATA_WIDTH / SERIALIZATION_FACTOR,
    parameter int DEST_WIDTH           = TID_WIDTH + TDEST_WIDTH,
    parameter int FLIT_BUFFER_DEPTH    = 2
) (
    input  logic                                      clk_noc,
    input  logic                                      rst_noc_sync,
    input  logic [NUM_CHANNELS-1:0]                   axis_in_tvalid,
    output logic [NUM_CHANNELS-1:0]                   axis_in_tready,
    input  logic [NUM_CHANNELS-1:0][TDATA_WIDTH-1:0]  axis_in_tdata,
    input  logic [NUM_CHANNELS-1:0]                   axis_in_tlast,
    input  logic [NUM_CHANNELS-1:0][TID_WIDTH-1:0]    axis_in_tid,
    input  logic [NUM_CHANNELS-1:0][TDEST_WIDTH-1:0]  axis_in_tdest,
    output logic [FLIT_WIDTH-1:0]                     data_out,
    output logic [DEST_WIDTH-1:0]                     dest_out,
    output logic                                      is_tail_out,
    output logic                                      send_out,
    input  logic                                      credit_in,
    output logic                                      credit_overflow_err
);

    localparam int CH_W  = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
    localparam int IDX_W = (SERIALIZATION_FACTOR > 1) ? $clog2(SERIALIZATION_FACTOR) : 1;
    localparam int CRD_W = $clog2(FLIT_BUFFER_DEPTH + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SERIALIZATION_FACTOR - 1);
    localparam logic [CRD_W-1:0] MAX_CRD  = CRD_W'(FLIT_BUFFER_DEPTH);

    typedef enum logic {ST_IDLE, ST_LOCKED} state_t;

    state_t                  state_q, state_d;
    logic [CH_W-1:0]         lock_q, lock_d;
    logic [CH_W-1:0]         rr_q, rr_d;
    logic                    beat_valid_q;
    logic [TDATA_WIDTH-1:0]  beat_data_q;
    logic [DEST_WIDTH-1:0]   beat_dest_q;
    logic                    beat_last_q;
    logic [IDX_W-1:0]        idx_q;
    logic [CRD_W-1:0]        credits_q;
    logic                    err_q;

    logic                    last_flit;
    logic                    beat_free;
    logic [CH_W-1:0]         cand;
    logic                    cand_found;
    logic [CH_W-1:0]         grant;
    logic                    grant_valid;
    logic                    handshake;

    function automatic logic [CH_W-1:0] wrap_add(input logic [CH_W-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= NUM_CHANNELS) s = s - NUM_CHANNELS;
        return CH_W'(s);
    endfunction

    assign send_out            = beat_valid_q && (credits_q != '0);
    assign last_flit           = (idx_q == LAST_IDX);
    assign beat_free           = !beat_valid_q || (send_out && last_flit);
    assign data_out            = beat_data_q[idx_q*FLIT_WIDTH +: FLIT_WIDTH];
    assign dest_out            = beat_dest_q;
    assign is_tail_out         = beat_valid_q && beat_last_q && last_flit;
    assign credit_overflow_err = err_q;

    // Arbitration: pick the round-robin candidate, drive tready and compute next arbiter state.
    always_comb begin
        cand           = '0;
        cand_found     = 1'b0;
        state_d        = state_q;
        lock_d         = lock_q;
        rr_d           = rr_q;
        axis_in_tready = '0;
        // Walk from the farthest offset back so the nearest valid channel to rr wins.
        for (int i = NUM_CHANNELS - 1; i >= 0; i--) begin
            if (axis_in_tvalid[wrap_add(rr_q, i)]) begin
                cand       = wrap_add(rr_q, i);
                cand_found = 1'b1;
            end
        end
        grant       = (state_q == ST_LOCKED) ? lock_q : cand;
        grant_valid = (state_q == ST_LOCKED) ? 1'b1 : cand_found;
        if (!rst_noc_sync && grant_valid) begin
            axis_in_tready[grant] = beat_free;
        end
        handshake = |(axis_in_tvalid & axis_in_tready);
        if (handshake) begin
            if (axis_in_tlast[grant]) begin
                state_d = ST_IDLE;
            end else begin
                state_d = ST_LOCKED;
                lock_d  = grant;
            end
            if (state_q == ST_IDLE) begin
                rr_d = wrap_add(grant, 1);
            end
        end
    end

    // Arbiter state register: packet lock owner and round-robin pointer.
    always_ff @(posedge clk_noc) begin
        if (rst_noc_sync) begin
            state_q <= ST_IDLE;
            lock_q  <= '0;
            rr_q    <= '0;
        end else begin
            state_q <= state_d;
            lock_q  <= lock_d;
            rr_q    <= rr_d;
        end
    end

    // Beat register and flit index: load on handshake, step per sent flit, retire on the last flit.
    always_ff @(posedge clk_noc) begin
        if (rst_noc_sync) begin
            beat_valid_q <= 1'b0;
            beat_data_q  <= '0;
            beat_dest_q  <= '0;
            beat_last_q  <= 1'b0;
            idx_q        <= '0;
        end else begin
            if (handshake) begin
                beat_valid_q <= 1'b1;
                beat_data_q  <= axis_in_tdata[grant];
                beat_dest_q  <= {axis_in_tid[grant], axis_in_tdest[grant]};
                beat_last_q  <= axis_in_tlast[grant];
            end else if (send_out && last_flit) begin
                beat_valid_q <= 1'b0;
            end
            if (send_out) begin
                idx_q <= last_flit ? '0 : idx_q + IDX_W'(1);
            end
        end
    end

    // Credit counter: returns and sends cancel; a return at full count is dropped and flagged.
    always_ff @(posedge clk_noc) begin
        if (rst_noc_sync) begin
            credits_q <= MAX_CRD;
            err_q     <= 1'b0;
        end else if (credit_in && !send_out) begin
            if (credits_q == MAX_CRD) begin
                err_q <= 1'b1;
            end else begin
                credits_q <= credits_q + CRD_W'(1);
            end
        end else if (!credit_in && send_out) begin
            credits_q <= credits_q - CRD_W'(1);
        end
    end

endmodule

// File: tb/tb_axis_mux_serializer_in.sv
// tb/tb_axis_mux_serializer_in.sv - scoreboard bench for axis_mux_serializer_in
module tb_axis_mux_serializer_in;

    localparam int NC = 4;

    typedef struct packed {
        logic [31:0] data;
        logic        last;
        logic [1:0]  tid;
        logic [1:0]  tdest;
    } beat_t;

    logic                  clk_noc = 1'b0;
    logic                  rst_noc_sync = 1'b1;
    logic [NC-1:0]         axis_in_tvalid = '0;
    logic [NC-1:0]         axis_in_tready;
    logic [NC-1:0][31:0]   axis_in_tdata = '0;
    logic [NC-1:0]         axis_in_tlast = '0;
    logic [NC-1:0][1:0]    axis_in_tid = '0;
    logic [NC-1:0][1:0]    axis_in_tdest = '0;
    logic [15:0]           data_out;
    logic [3:0]            dest_out;
    logic                  is_tail_out;
    logic                  send_out;
    logic                  credit_in = 1'b0;
    logic                  credit_overflow_err;

    beat_t       src_q [NC][$];
    logic [20:0] sb_q[$];
    logic [NC-1:0] hs_q = '0;
    int          hs_cnt [NC] = '{default: 0};
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          send_cnt = 0;
    int          last_send_cyc = 0;
    int          credit_mode = 1;

    axis_mux_serializer_in dut (
        .clk_noc             (clk_noc),
        .rst_noc_sync        (rst_noc_sync),
        .axis_in_tvalid      (axis_in_tvalid),
        .axis_in_tready      (axis_in_tready),
        .axis_in_tdata       (axis_in_tdata),
        .axis_in_tlast       (axis_in_tlast),
        .axis_in_tid         (axis_in_tid),
        .axis_in_tdest       (axis_in_tdest),
        .data_out            (data_out),
        .dest_out            (dest_out),
        .is_tail_out         (is_tail_out),
        .send_out            (send_out),
        .credit_in           (credit_in),
        .credit_overflow_err (credit_overflow_err)
    );

    always #5 clk_noc = ~clk_noc;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic fail_timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: bound expired, required event not seen", name);
    endtask

    always @(posedge clk_noc) begin
        cyc  <= cyc + 1;
        hs_q <= axis_in_tvalid & axis_in_tready;
        for (int c = 0; c < NC; c++) hs_cnt[c] <= hs_cnt[c] + int'(axis_in_tvalid[c] & axis_in_tready[c]);
    end

    // Source driver: retire a beat after its handshake, then present the queue head.
    always @(negedge clk_noc) begin
        for (int c = 0; c < NC; c++) begin
            if (hs_q[c] && src_q[c].size() > 0) void'(src_q[c].pop_front());
            if (src_q[c].size() > 0) begin
                axis_in_tvalid[c] = 1'b1;
                axis_in_tdata[c]  = src_q[c][0].data;
                axis_in_tlast[c]  = src_q[c][0].last;
                axis_in_tid[c]    = src_q[c][0].tid;
                axis_in_tdest[c]  = src_q[c][0].tdest;
            end else begin
                axis_in_tvalid[c] = 1'b0;
            end
        end
    end

    // Router model: mode 1 returns a credit with every flit, mode 2 only with tail flits.
    always @(negedge clk_noc) begin
        if (credit_mode == 1) credit_in = send_out;
        else if (credit_mode == 2) credit_in = send_out & is_tail_out;
    end

    // Monitor: every sent flit is compared with the scoreboard head.
    always @(negedge clk_noc) begin
        if (send_out === 1'b1) begin
            send_cnt++;
            last_send_cyc = cyc;
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_flit: got data=%0h dest=%0h tail=%0b, required no flit",
                         data_out, dest_out, is_tail_out);
            end else begin
                check("flit", 64'({data_out, dest_out, is_tail_out}), 64'(sb_q.pop_front()));
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk_noc);
            #2;
        end
    endtask

    task automatic push_beat(input int ch, input logic [31:0] d, input logic l,
                             input logic [1:0] tid, input logic [1:0] td);
        beat_t b;
        b.data  = d;
        b.last  = l;
        b.tid   = tid;
        b.tdest = td;
        src_q[ch].push_back(b);
    endtask

    task automatic exp_flit(input logic [15:0] d, input logic [3:0] dest, input logic tail);
        sb_q.push_back({d, dest, tail});
    endtask

    task automatic pulse_credit();
        credit_in = 1'b1;
        tick(1);
        credit_in = 1'b0;
    endtask

    task automatic wait_send(input string name, output int c);
        int n;
        n = 0;
        while (send_out !== 1'b1 && n < 50) begin
            tick(1);
            n++;
        end
        c = cyc;
        if (n >= 50) fail_timeout(name);
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 300) begin
            tick(1);
            n++;
        end
        check(name, 64'(sb_q.size()), 64'd0);
    endtask

    initial begin
        int t0;
        int p;
        int s0;
        int start1;
        int order [8] = '{3, 0, 1, 2, 3, 0, 1, 2};

        tick(3);
        check("rst_tready", 64'(axis_in_tready), 64'd0);
        check("rst_send", 64'(send_out), 64'd0);
        check("rst_data", 64'(data_out), 64'd0);
        check("rst_dest", 64'(dest_out), 64'd0);
        check("rst_tail", 64'(is_tail_out), 64'd0);
        check("rst_err", 64'(credit_overflow_err), 64'd0);
        rst_noc_sync = 1'b0;
        tick(1);

        // Single beat on ch0: two flits on consecutive cycles, tail only on the second.
        push_beat(0, 32'hAABB_CCDD, 1'b1, 2'd1, 2'd2);
        exp_flit(16'hCCDD, 4'b0110, 1'b0);
        exp_flit(16'hAABB, 4'b0110, 1'b1);
        p = cyc;
        wait_send("t1_first_send", t0);
        check("t1_latency", 64'(t0), 64'(p + 1));
        drain("t1_drain");
        check("t1_consecutive", 64'(last_send_cyc - t0), 64'd1);

        // ch1 three-beat packet locks out ch2 until its tail beat.
        push_beat(1, 32'h1111_0001, 1'b0, 2'd1, 2'd1);
        push_beat(1, 32'h1111_0002, 1'b0, 2'd1, 2'd1);
        push_beat(1, 32'h1111_0003, 1'b1, 2'd1, 2'd1);
        push_beat(2, 32'h2222_0001, 1'b1, 2'd2, 2'd3);
        exp_flit(16'h0001, 4'b0101, 1'b0);
        exp_flit(16'h1111, 4'b0101, 1'b0);
        exp_flit(16'h0002, 4'b0101, 1'b0);
        exp_flit(16'h1111, 4'b0101, 1'b0);
        exp_flit(16'h0003, 4'b0101, 1'b0);
        exp_flit(16'h1111, 4'b0101, 1'b1);
        exp_flit(16'h0001, 4'b1011, 1'b0);
        exp_flit(16'h2222, 4'b1011, 1'b1);
        start1 = hs_cnt[1];
        for (int i = 0; i < 40 && sb_q.size() != 0; i++) begin
            tick(1);
            if (hs_cnt[1] < start1 + 3) check("t2_ch2_blocked", 64'(axis_in_tready[2]), 64'd0);
        end
        drain("t2_drain");

        // All four channels busy: strict rotation starting after the last grant (ch2), full rate.
        for (int c = 0; c < NC; c++)
            for (int k = 0; k < 2; k++)
                push_beat(c, 32'hC000_0000 | (c << 8) | k, 1'b1, 2'(c), ~2'(c));
        for (int j = 0; j < 8; j++) begin
            exp_flit(16'(order[j] << 8 | j / 4), {2'(order[j]), ~2'(order[j])}, 1'b0);
            exp_flit(16'hC000, {2'(order[j]), ~2'(order[j])}, 1'b1);
        end
        wait_send("t3_first_send", t0);
        drain("t3_drain");
        check("t3_throughput", 64'(last_send_cyc - t0), 64'd15);

        // No credit returns: only FLIT_BUFFER_DEPTH flits leave, then one per returned credit.
        credit_mode = 0;
        credit_in = 1'b0;
        push_beat(0, 32'h0A0B_0C0D, 1'b1, 2'd0, 2'd1);
        push_beat(0, 32'h0102_0304, 1'b1, 2'd0, 2'd1);
        exp_flit(16'h0C0D, 4'b0001, 1'b0);
        exp_flit(16'h0A0B, 4'b0001, 1'b1);
        exp_flit(16'h0304, 4'b0001, 1'b0);
        exp_flit(16'h0102, 4'b0001, 1'b1);
        s0 = send_cnt;
        tick(10);
        check("t4_two_flits", 64'(send_cnt - s0), 64'd2);
        check("t4_stalled", 64'(send_out), 64'd0);
        pulse_credit();
        tick(10);
        check("t4_one_more", 64'(send_cnt - s0), 64'd3);
        pulse_credit();
        tick(10);
        check("t4_fourth", 64'(send_cnt - s0), 64'd4);
        pulse_credit();
        pulse_credit();
        drain("t4_drain");

        // Credit returned alongside the tail flit keeps the count at 1; then overflow at full.
        credit_mode = 2;
        push_beat(0, 32'h5555_6666, 1'b1, 2'd2, 2'd2);
        exp_flit(16'h6666, 4'b1010, 1'b0);
        exp_flit(16'h5555, 4'b1010, 1'b1);
        drain("t5_drain");
        credit_mode = 0;
        credit_in = 1'b0;
        check("t5_err_clear", 64'(credit_overflow_err), 64'd0);
        pulse_credit();
        tick(2);
        check("t5_refill_no_err", 64'(credit_overflow_err), 64'd0);
        pulse_credit();
        tick(2);
        check("t5_overflow", 64'(credit_overflow_err), 64'd1);
        tick(5);
        check("t5_err_sticky", 64'(credit_overflow_err), 64'd1);

        // Reset after the first flit discards the rest of the beat and restores credits.
        push_beat(0, 32'h1234_5678, 1'b1, 2'd0, 2'd3);
        exp_flit(16'h5678, 4'b0011, 1'b0);
        wait_send("t6_first_send", t0);
        rst_noc_sync = 1'b1;
        tick(1);
        check("t6_send_low", 64'(send_out), 64'd0);
        check("t6_tail_low", 64'(is_tail_out), 64'd0);
        check("t6_data_zero", 64'(data_out), 64'd0);
        check("t6_err_clear", 64'(credit_overflow_err), 64'd0);
        check("t6_tready_low", 64'(axis_in_tready), 64'd0);
        rst_noc_sync = 1'b0;
        push_beat(2, 32'hFEED_BEEF, 1'b1, 2'd3, 2'd0);
        exp_flit(16'hBEEF, 4'b1100, 1'b0);
        exp_flit(16'hFEED, 4'b1100, 1'b1);
        s0 = send_cnt;
        tick(10);
        check("t6_fresh_flits", 64'(send_cnt - s0), 64'd2);
        drain("t6_drain");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
